// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the Morse symbol sequencer.
// Unit constants are in tick periods; the unit timer is 3 bits wide.
package morse_pkg;

  localparam int MAX_LEN_DEF    = 5;
  localparam int UNITS_DOT      = 1;
  localparam int UNITS_DASH     = 3;
  localparam int UNITS_GAP      = 1;
  localparam int UNITS_LGAP     = 3;
  localparam int UNITS_WGAP     = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    MARK  = 3'd2,
    SPACE = 3'd3,
    LGAP  = 3'd4
  } morse_state_e;

  function automatic logic [2:0] mark_units(input logic is_dash,
                                            input logic [2:0] dot_u,
                                            input logic [2:0] dash_u);
    return is_dash ? dash_u : dot_u;
  endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Character request/keying bundle between encoder, sequencer and LED/tone driver.
// Handshake: start is taken on any refclk edge where ready=1; abort/tick are single-cycle strobes.
interface morse_symbol_sequencer_if #(parameter int MAX_LEN = 5);
  import morse_pkg::*;

  logic               tick;
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [2:0]         length;
  logic               abort;
  logic               ready;
  logic               busy;
  logic               key_out;
  logic               done;
  morse_state_e       state;

  modport master (
    output tick, start, pattern, length, abort,
    input  ready, busy, key_out, done, state
  );

  modport slave (
    input  tick, start, pattern, length, abort,
    output ready, busy, key_out, done, state
  );
endinterface

// File: rtl/morse_unit_timer.sv
// Loadable 3-bit down-counter advanced by tick; expired flags the tick that takes it 1 -> 0.
// load beats tick so a phase can reload on the very tick that ends the previous one.
module morse_unit_timer (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clear,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       expired,
  output logic [2:0] count
);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else if (clear) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign expired = tick && (count == 3'd1);

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Plays one character's dots/dashes onto key_out, one Morse unit per tick.
// key_out and done are registered so every edge lands one refclk after its tick.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_LEN          = MAX_LEN_DEF,
  parameter int DOT_UNITS        = UNITS_DOT,
  parameter int DASH_UNITS       = UNITS_DASH,
  parameter int GAP_UNITS        = UNITS_GAP,
  parameter int LETTER_GAP_UNITS = UNITS_LGAP,
  parameter int WORD_GAP_UNITS   = UNITS_WGAP
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  morse_symbol_sequencer_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN + 1);

  morse_state_e       state_q, state_d;
  logic               key_q, key_d;
  logic               done_q, done_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [2:0]         len_q, len_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      idx_nx;

  logic       t_clear, t_load, t_expired;
  logic [2:0] t_val, t_count;

  morse_unit_timer u_timer (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .tick     (bus.tick),
    .clear    (t_clear),
    .load     (t_load),
    .load_val (t_val),
    .expired  (t_expired),
    .count    (t_count)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
      pat_q   <= '0;
      len_q   <= 3'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      done_q  <= done_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    done_d  = 1'b0;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    t_clear = 1'b0;
    t_load  = 1'b0;
    t_val   = 3'd0;

    // abort outranks any tick arriving in the same cycle
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      key_d   = 1'b0;
      t_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            pat_d   = bus.pattern;
            len_d   = (bus.length > 3'(MAX_LEN)) ? 3'(MAX_LEN) : bus.length;
            idx_d   = '0;
            state_d = ALIGN;
          end
        end
        ALIGN: begin
          if (bus.tick) begin
            t_load = 1'b1;
            if (len_q != 3'd0) begin
              state_d = MARK;
              key_d   = 1'b1;
              t_val   = mark_units(pat_q[0], 3'(DOT_UNITS), 3'(DASH_UNITS));
            end else begin
              state_d = LGAP;
              t_val   = 3'(WORD_GAP_UNITS);
            end
          end
        end
        MARK: begin
          if (t_expired) begin
            key_d  = 1'b0;
            t_load = 1'b1;
            if (3'(idx_nx) < len_q) begin
              state_d = SPACE;
              t_val   = 3'(GAP_UNITS);
            end else begin
              state_d = LGAP;
              t_val   = 3'(LETTER_GAP_UNITS);
            end
          end
        end
        SPACE: begin
          if (t_expired) begin
            idx_d   = idx_nx;
            state_d = MARK;
            key_d   = 1'b1;
            t_load  = 1'b1;
            t_val   = mark_units(pat_q[idx_nx], 3'(DOT_UNITS), 3'(DASH_UNITS));
          end
        end
        LGAP: begin
          if (t_expired) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          key_d   = 1'b0;
          t_clear = 1'b1;
        end
      endcase
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.key_out = key_q;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule
